mode_sequencer: RTL
===================

Name: mode_sequencer

Overview:
- Game-phase sequencer that drives the 3-bit mode bus M into the tick controller and consumes its tick output C. It is the other end of the M/C interface.
- Advances through idle, ready, play, score, win and lose phases using player start/hit inputs and C timeouts.
- Outputs the current mode, round number and score for the display logic.

Parameters:
- ROUNDS, 3: number of successful hits needed to reach WIN; legal range 1 to 2^RND_W-1.
- RND_W, 4: width of the round counter.
- SCORE_W, 8: width of the score counter.
- READY_CYCLES, 16: clk cycles spent in READY before PLAY; must be at least 1.
- WIN_HOLD, 1024: clk cycles spent in WIN before returning to IDLE; must be at least 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- C  in  1  tick from the tick controller. Goes high after its interval while M is 000/010/101 and stays high until M leaves those codes.
- start  in  1  debounced start button, level.
- hit  in  1  debounced player-hit button, level.
- M  out  3  mode code: 000 IDLE, 001 READY, 010 PLAY, 011 SCORE, 100 WIN, 101 LOSE. 110 and 111 are never driven.
- round  out  RND_W  hits completed in the current game.
- score  out  SCORE_W  cumulative hits since last reset; saturating.
- game_over  out  1  one-cycle pulse on entry to WIN or LOSE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - M=000, round=0, score=0, game_over=0.
  - Internal counter=0; edge registers c_q, start_q, hit_q all 0.
  - Reset mid-game aborts to IDLE immediately.
- Edge detection:
  - Registered each cycle: c_q<=C, start_q<=start, hit_q<=hit.
  - tick=C&~c_q, st=start&~start_q, ht=hit&~hit_q.
  - A held button counts once. A C stuck high yields one tick per visit to a tick mode.
- Latency: an event seen at edge n changes M at edge n+1 (M is a registered FSM state).
- IDLE (000):
  - st → READY; clear round and the internal counter.
  - tick is ignored (attract-blink only).
- READY (001):
  - Counter increments every cycle.
  - When counter == READY_CYCLES-1 → PLAY and counter clears.
  - st and ht are ignored.
- PLAY (010):
  - ht → SCORE.
  - Else tick → LOSE and pulse game_over.
  - If ht and tick occur in the same cycle, ht wins.
  - st is ignored.
- SCORE (011), one cycle only:
  - round <= round+1; score <= score+1, saturating at 2^SCORE_W-1.
  - If round+1 == ROUNDS → WIN and pulse game_over; else → READY.
- WIN (100):
  - Counter increments; at WIN_HOLD-1 → IDLE.
  - st → IDLE early.
- LOSE (101):
  - tick (C is re-armed because M left 010) → IDLE.
  - st → IDLE early.
- M is never 110/111. An illegal state register value recovers to IDLE on the next edge.
- Widths: round compare is done in RND_W bits. The internal counter is wide enough for max(READY_CYCLES, WIN_HOLD).

Test Plan (ROUNDS=3, READY_CYCLES=4, WIN_HOLD=8):
- Reset, then hold start high 10 cycles:
  - M goes 000 → 001 one cycle after the first high sample, then → 010 exactly 4 cycles later.
  - Only one game starts.
- Three hit pulses, each in PLAY, with no tick:
  - M walks 010 → 011 → 001 → 010 ... with round = 1, 2, then 3.
  - The third SCORE goes to 100 and game_over pulses once.
  - After 8 cycles M = 000; score = 3.
- In PLAY, raise C and hold it high:
  - M = 101 the next cycle, game_over = 1 for one cycle.
  - M stays 101 while C stays high. Drop C for 1 cycle, raise it again: M returns to 000.
- In PLAY, assert hit and a rising C in the same cycle → M = 011, not 101.
- Assert rst in PLAY with round = 2 and score = 5 → next cycle M = 000, round = 0, score = 0.
- SCORE_W=2: win two games of 3 rounds → score saturates at 3, never wraps to 0.

Source files
------------

// File: rtl/mode_sequencer.sv
// Game-phase sequencer: drives mode bus M into the tick controller and reacts to
// its tick C plus the start/hit buttons; exposes round, score and a game_over pulse.
module mode_sequencer #(
    parameter int ROUNDS       = 3,
    parameter int RND_W        = 4,
    parameter int SCORE_W      = 8,
    parameter int READY_CYCLES = 16,
    parameter int WIN_HOLD     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               C,
    input  logic               start,
    input  logic               hit,
    output logic [2:0]         M,
    output logic [RND_W-1:0]   round,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam int MAX_CYC = (READY_CYCLES > WIN_HOLD) ? READY_CYCLES : WIN_HOLD;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_HOLD - 1);
    localparam logic [RND_W-1:0] ROUNDS_R   = RND_W'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_READY = 3'b001,
        S_PLAY  = 3'b010,
        S_SCORE = 3'b011,
        S_WIN   = 3'b100,
        S_LOSE  = 3'b101
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               go_q, go_d;
    logic               c_q, start_q, hit_q;
    logic               tick, st, ht;

    // Rising-edge detectors: a held button or a C stuck high yields a single event.
    assign tick = C & ~c_q;
    assign st   = start & ~start_q;
    assign ht   = hit & ~hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            round_q <= '0;
            score_q <= '0;
            go_q    <= 1'b0;
            c_q     <= 1'b0;
            start_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            score_q <= score_d;
            go_q    <= go_d;
            c_q     <= C;
            start_q <= start;
            hit_q   <= hit;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        score_d = score_q;
        go_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (st) begin
                    state_d = S_READY;
                    round_d = '0;
                    cnt_d   = '0;
                end
            end
            S_READY: begin
                if (cnt_q == READY_LAST) begin
                    state_d = S_PLAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PLAY: begin
                // A hit beats a timeout arriving in the same cycle.
                if (ht) begin
                    state_d = S_SCORE;
                end else if (tick) begin
                    state_d = S_LOSE;
                    go_d    = 1'b1;
                end
            end
            S_SCORE: begin
                round_d = round_q + 1'b1;
                if (score_q != '1) begin
                    score_d = score_q + 1'b1;
                end
                cnt_d = '0;
                if (round_d == ROUNDS_R) begin
                    state_d = S_WIN;
                    go_d    = 1'b1;
                end else begin
                    state_d = S_READY;
                end
            end
            S_WIN: begin
                if (st || (cnt_q == WIN_LAST)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOSE: begin
                if (st || tick) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign M         = state_q;
    assign round     = round_q;
    assign score     = score_q;
    assign game_over = go_q;

endmodule
